sar_search_ctrl: RTL and testbench

- Successive-approximation controller: the inverse of a magnitude comparator.
- It drives a trial word to an external comparator and consumes the comparator's e/g/l flags. It converges MSB-first on the hidden target the comparator is checking against.
- Sits beside comparator cells in threshold-search and ADC-style datapaths.

---
 rtl/sar_pkg.sv | 32 +++
 rtl/sar_step.sv | 51 +++++
 rtl/sar_search_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sar_search_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared types and helpers for the successive-approximation search controller.
//   - sar_state_t : FSM state encoding (IDLE, TEST, DONE)
//   - FLAG_E/G/L  : bit positions of the comparator flags in the {e,g,l} vector
//   - one_hot3()  : flag-consistency check, used when SAR_FLAG_CHECK_EN is set
// -----------------------------------------------------------------------------
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TEST = 2'd1,
      DONE = 2'd2
   } sar_state_t;

   // Flag vector is packed as {e, g, l}
   localparam int FLAG_E = 2;
   localparam int FLAG_G = 1;
   localparam int FLAG_L = 0;
   localparam int FLAG_W = 3;

   // True when exactly one of the three comparator flags is asserted
   function automatic logic one_hot3(input logic [FLAG_W-1:0] flags);
      logic r_ok;
      case (flags)
         3'b001, 3'b010, 3'b100: r_ok = 1'b1;
         default:                r_ok = 1'b0;
      endcase
      return r_ok;
   endfunction

endpackage

// File: rtl/sar_step.sv
// -----------------------------------------------------------------------------
// sar_step
// Combinational single-bit resolution step of the SAR search.
// Ports:
//   trial      in  current trial word driven to the comparator
//   k          in  index of the bit currently under test
//   flags      in  comparator flags {e,g,l}
//   next_trial out trial word after resolving bit k (and setting bit k-1)
//   last_bit   out k is the LSB
//   finish     out search completes this cycle (exact hit or LSB resolved)
// Priority e > g > l; no flag asserted behaves as l.
// -----------------------------------------------------------------------------
module sar_step
   import sar_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int KW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]  trial,
   input  logic [KW-1:0]     k,
   input  logic [FLAG_W-1:0] flags,
   output logic [WIDTH-1:0]  next_trial,
   output logic              last_bit,
   output logic              finish
);

   logic w_e;
   logic w_g;
   logic w_unused_l;   // l only matters as "not e and not g", which is the default branch

   assign w_e        = flags[FLAG_E];
   assign w_g        = flags[FLAG_G];
   assign w_unused_l = flags[FLAG_L];
   assign last_bit   = (k == '0);
   assign finish     = w_e || last_bit;

   always_comb begin
      next_trial = trial;
      if (!w_e) begin
         // target is below trial: bit k must be 0
         if (w_g) begin
            next_trial[k] = 1'b0;
         end
         // seed the next bit down as the new guess
         if (!last_bit) begin
            next_trial[k - KW'(1)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sar_search_ctrl.sv
// -----------------------------------------------------------------------------
// sar_search_ctrl
// Successive-approximation controller: drives a trial word to an external
// magnitude comparator and converges MSB-first on the comparator's hidden
// target using its e/g/l flags. The result is the largest value <= target.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   begin a search (accepted only in IDLE)
//   e/g/l   in   comparator flags for the registered trial (same-cycle)
//   trial   out  registered trial word
//   busy    out  high while searching
//   done    out  one-cycle completion pulse
//   result  out  final value, held until the next completion
//   found   out  an exact match was seen during the search
//   err     out  inconsistent flag vector seen (sticky until next start)
// Optional feature: define SAR_FLAG_CHECK_EN to abort on non-one-hot flags and
// report it on err; otherwise err is tied low and priority e > g > l applies.
// -----------------------------------------------------------------------------
module sar_search_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             e,
   input  logic             g,
   input  logic             l,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);

   localparam int KW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [KW-1:0]    K_TOP   = KW'(WIDTH-1);

   sar_state_t        r_state;
   logic [WIDTH-1:0]  r_trial;
   logic [KW-1:0]     r_k;
   logic              r_busy;
   logic              r_done;
   logic [WIDTH-1:0]  r_result;
   logic              r_found;

   logic [FLAG_W-1:0] w_flags;
   logic [WIDTH-1:0]  w_next_trial;
   logic              w_last_bit;
   logic              w_finish;

   assign w_flags = {e, g, l};

   sar_step #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_step (
      .trial      (r_trial),
      .k          (r_k),
      .flags      (w_flags),
      .next_trial (w_next_trial),
      .last_bit   (w_last_bit),
      .finish     (w_finish)
   );

`ifdef SAR_FLAG_CHECK_EN
   logic r_err;
   logic w_flag_bad;
   assign w_flag_bad = !one_hot3(w_flags);
`else
   logic w_unused_last;
   assign w_unused_last = w_last_bit;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_trial  <= '0;
         r_k      <= K_TOP;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_found  <= 1'b0;
`ifdef SAR_FLAG_CHECK_EN
         r_err    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= TEST;
                  r_busy  <= 1'b1;
                  r_trial <= MSB_ONE;
                  r_k     <= K_TOP;
                  r_found <= 1'b0;
`ifdef SAR_FLAG_CHECK_EN
                  r_err   <= 1'b0;
`endif
               end
            end

            TEST: begin
`ifdef SAR_FLAG_CHECK_EN
               if (w_flag_bad) begin
                  // untrustworthy comparator: stop with the current guess
                  r_err    <= 1'b1;
                  r_result <= r_trial;
                  r_found  <= 1'b0;
                  r_state  <= DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end else
`endif
               begin
                  r_trial <= w_next_trial;
                  if (w_finish) begin
                     // next_trial equals trial on a hit and is the resolved word on the LSB
                     r_result <= w_next_trial;
                     if (w_flags[FLAG_E]) begin
                        r_found <= 1'b1;
                     end
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_k <= r_k - KW'(1);
                  end
               end
            end

            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign trial  = r_trial;
   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign found  = r_found;
`ifdef SAR_FLAG_CHECK_EN
   assign err    = r_err;
`else
   assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_search_ctrl
// Directed bench for sar_search_ctrl (WIDTH=8) with a behavioural comparator
// and an override hook that forces arbitrary flag vectors on a chosen cycle.
// -----------------------------------------------------------------------------
module tb_sar_search_ctrl;

   localparam int WIDTH = 8;
   localparam int MAXC  = 20;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             e, g, l;
   logic [WIDTH-1:0] trial;
   logic             busy, done, found, err;
   logic [WIDTH-1:0] result;

   logic [WIDTH-1:0] target;
   logic             inj;
   logic [2:0]       inj_flags;

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] log_trial  [0:MAXC];
   logic             log_busy   [0:MAXC];
   logic [WIDTH-1:0] log_result [0:MAXC];
   logic             log_found  [0:MAXC];
   logic             log_done   [0:MAXC];

   always #5 clk = ~clk;

   sar_search_ctrl #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .e      (e),
      .g      (g),
      .l      (l),
      .trial  (trial),
      .busy   (busy),
      .done   (done),
      .result (result),
      .found  (found),
      .err    (err)
   );

   // behavioural comparator against the hidden target
   always_comb begin
      if (inj) begin
         {e, g, l} = inj_flags;
      end else begin
         e = (trial == target);
         g = (trial >  target);
         l = (trial <  target);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One search transaction. Cycle 0 is the cycle start is high; cycle c is
   // sampled 1 time unit after the c-th following rising edge.
   task automatic run(input logic [WIDTH-1:0] tgt, input int inj_cyc,
                      input logic [2:0] iflags, input int restart_cyc,
                      input int rst_cyc, output int done_cyc);
      repeat (2) @(posedge clk);
      target    = tgt;
      inj_flags = iflags;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      done_cyc = -1;
      for (int c = 1; c <= MAXC; c++) begin
         log_trial[c]  = trial;
         log_busy[c]   = busy;
         log_result[c] = result;
         log_found[c]  = found;
         log_done[c]   = done;
         if (done) begin
            done_cyc = c;
            break;
         end
         inj   = (c == inj_cyc);
         start = (c == restart_cyc);
         rst   = (c == rst_cyc);
         @(posedge clk);
         #1;
      end
      inj   = 1'b0;
      start = 1'b0;
      rst   = 1'b0;
      $display("search target=0x%02h done_cycle=%0d result=0x%02h found=%0b err=%0b",
               tgt, done_cyc, result, found, err);
      if (done_cyc > 0) begin
         @(posedge clk);
         #1;
         chk("done_single_pulse", {31'd0, done}, 32'd0);
      end
   endtask

   int dc;
   logic [WIDTH-1:0] seq_a5 [1:8];

   initial begin
      seq_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      rst = 1'b1; start = 1'b0; inj = 1'b0; inj_flags = 3'b000; target = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_trial",  {24'd0, trial},  32'd0);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_done",   {31'd0, done},   32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_found",  {31'd0, found},  32'd0);
      chk("rst_err",    {31'd0, err},    32'd0);
      rst = 1'b0;

      // full sequence, target 0xA5
      run(8'hA5, 0, 3'b000, 0, 0, dc);
      for (int c = 1; c <= 8; c++) begin
         chk($sformatf("a5_trial_c%0d", c), {24'd0, log_trial[c]}, {24'd0, seq_a5[c]});
         chk($sformatf("a5_busy_c%0d", c),  {31'd0, log_busy[c]},  32'd1);
      end
      chk("a5_done_cycle", dc, 32'd9);
      chk("a5_busy_at_done", {31'd0, log_busy[9]}, 32'd0);
      chk("a5_result", {24'd0, result}, 32'hA5);
      chk("a5_found",  {31'd0, found},  32'd1);
      chk("a5_err",    {31'd0, err},    32'd0);

      // early exit on first trial
      run(8'h80, 0, 3'b000, 0, 0, dc);
      chk("t80_done_cycle", dc, 32'd2);
      chk("t80_result", {24'd0, result}, 32'h80);
      chk("t80_found",  {31'd0, found},  32'd1);

      // upper boundary
      run(8'hFF, 0, 3'b000, 0, 0, dc);
      chk("tff_done_cycle", dc, 32'd9);
      chk("tff_result", {24'd0, result}, 32'hFF);
      chk("tff_found",  {31'd0, found},  32'd1);

      // lower boundary: never an exact hit
      run(8'h00, 0, 3'b000, 0, 0, dc);
      chk("t00_done_cycle", dc, 32'd9);
      chk("t00_result", {24'd0, result}, 32'h00);
      chk("t00_found",  {31'd0, found},  32'd0);

      // start re-pulsed during TEST is ignored; 0x3C hits on the sixth trial
      run(8'h3C, 0, 3'b000, 3, 0, dc);
      chk("t3c_done_cycle", dc, 32'd7);
      chk("t3c_result", {24'd0, result}, 32'h3C);
      chk("t3c_found",  {31'd0, found},  32'd1);
      chk("t3c_busy_after", {31'd0, busy}, 32'd0);

      // reset asserted during cycle 4 aborts the search
      run(8'hA5, 0, 3'b000, 0, 4, dc);
      chk("rst_mid_no_done", dc, -32'sd1);
      chk("rst_mid_result_before", {24'd0, log_result[4]}, 32'h3C);
      chk("rst_mid_trial",  {24'd0, log_trial[5]},  32'd0);
      chk("rst_mid_busy",   {31'd0, log_busy[5]},   32'd0);
      chk("rst_mid_result", {24'd0, log_result[5]}, 32'd0);
      chk("rst_mid_found",  {31'd0, log_found[5]},  32'd0);
      chk("rst_mid_err",    {31'd0, err},           32'd0);

      // e and g both high on the third trial (0xA0)
      run(8'hA5, 3, 3'b110, 0, 0, dc);
      chk("flt_done_cycle", dc, 32'd4);
      chk("flt_result", {24'd0, result}, 32'hA0);
`ifdef SAR_FLAG_CHECK_EN
      chk("flt_found", {31'd0, found}, 32'd0);
      chk("flt_err",   {31'd0, err},   32'd1);
`else
      chk("flt_found", {31'd0, found}, 32'd1);
      chk("flt_err",   {31'd0, err},   32'd0);
`endif

      // no flag on the second trial (0xC0) acts as l when unchecked
      run(8'hA5, 2, 3'b000, 0, 0, dc);
`ifdef SAR_FLAG_CHECK_EN
      chk("none_done_cycle", dc, 32'd3);
      chk("none_result", {24'd0, result}, 32'hC0);
      chk("none_err",    {31'd0, err},    32'd1);
`else
      // C0 kept, then A5 < E0,D0,C8,C4,C2,C1 all g -> C0, no hit
      chk("none_done_cycle", dc, 32'd9);
      chk("none_result", {24'd0, result}, 32'hC0);
      chk("none_found",  {31'd0, found},  32'd0);
`endif

      // a fresh start clears err
      run(8'h80, 0, 3'b000, 0, 0, dc);
      chk("clr_err",    {31'd0, err},    32'd0);
      chk("clr_result", {24'd0, result}, 32'h80);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
